// File: rtl/truth_table_sweeper_if.sv
// Handshake and result bundle between the truth-table sweeper and the logic that
// owns the two function units under comparison.
interface truth_table_sweeper_if #(
   parameter int N_IN = 4
);
   logic                   start;
   logic                   abort;
   logic [N_IN-1:0]        x;
   logic                   fa;
   logic                   fb;
   logic                   busy;
   logic                   done;
   logic                   equal;
   logic [N_IN:0]          mism_cnt;
   logic [N_IN-1:0]        first_bad;
   logic                   first_valid;
   logic [(1<<N_IN)-1:0]   minterms_a;

   modport master (
      output start, abort, fa, fb,
      input  x, busy, done, equal, mism_cnt, first_bad, first_valid, minterms_a
   );

   modport slave (
      input  start, abort, fa, fb,
      output x, busy, done, equal, mism_cnt, first_bad, first_valid, minterms_a
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks x through every minterm, compares two combinational function units at each one,
// and reports mismatch count, first failing minterm and fa's on-set mask.
module truth_table_sweeper #(
   parameter int N_IN   = 4,
   parameter int SETTLE = 1
) (
   input logic                  clk,
   input logic                  rst_n,
   truth_table_sweeper_if.slave bus
);
   localparam int              N_MT     = 1 << N_IN;
   localparam logic [1:0]      ST_IDLE  = 2'd0;
   localparam logic [1:0]      ST_WAIT  = 2'd1;
   localparam logic [1:0]      ST_FIN   = 2'd2;
   localparam logic [3:0]      SETTLE_V = 4'(SETTLE);
   localparam logic [N_IN-1:0] X_LAST   = {N_IN{1'b1}};

   logic [1:0]      state_reg, state_next;
   logic [3:0]      scnt_reg, scnt_next;
   logic [N_IN-1:0] x_reg, x_next;
   logic [N_IN:0]   mism_cnt_reg, mism_cnt_next;
   logic [N_IN-1:0] first_bad_reg, first_bad_next;
   logic            first_valid_reg, first_valid_next;
   logic            equal_reg, equal_next;
   logic [N_MT-1:0] minterms_reg, minterms_next;
   logic            sample;
   logic            clear;

   // fa/fb are only meaningful once the settle window for the current x has elapsed
   assign sample = (state_reg == ST_WAIT) && !bus.abort && (scnt_reg == 4'd0);
   assign clear  = bus.abort || ((state_reg == ST_IDLE) && bus.start);

   generate
      for (genvar gi = 0; gi < N_MT; gi++) begin : g_mask
         localparam logic [N_IN-1:0] IDX = gi;
         assign minterms_next[gi] = clear ? 1'b0 :
                                    (sample && (x_reg == IDX)) ? bus.fa : minterms_reg[gi];
      end
   endgenerate

   always_comb begin
      state_next       = state_reg;
      scnt_next        = scnt_reg;
      x_next           = x_reg;
      mism_cnt_next    = mism_cnt_reg;
      first_bad_next   = first_bad_reg;
      first_valid_next = first_valid_reg;
      equal_next       = equal_reg;
      if (bus.abort) begin
         state_next       = ST_IDLE;
         scnt_next        = 4'd0;
         x_next           = '0;
         mism_cnt_next    = '0;
         first_bad_next   = '0;
         first_valid_next = 1'b0;
         equal_next       = 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.start) begin
                  state_next       = ST_WAIT;
                  scnt_next        = SETTLE_V;
                  x_next           = '0;
                  mism_cnt_next    = '0;
                  first_bad_next   = '0;
                  first_valid_next = 1'b0;
                  equal_next       = 1'b0;
               end
            end
            ST_WAIT: begin
               if (scnt_reg != 4'd0) begin
                  scnt_next = scnt_reg - 4'd1;
               end else begin
                  if (bus.fa != bus.fb) begin
                     mism_cnt_next = mism_cnt_reg + 1'b1;
                     if (!first_valid_reg) begin
                        first_bad_next   = x_reg;
                        first_valid_next = 1'b1;
                     end
                  end
                  if (x_reg == X_LAST) begin
                     state_next = ST_FIN;
                  end else begin
                     x_next    = x_reg + 1'b1;
                     scnt_next = SETTLE_V;
                  end
               end
            end
            ST_FIN: begin
               // mism_cnt is final here, so the verdict is taken on the edge leaving FIN
               equal_next = (mism_cnt_reg == '0);
               state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= ST_IDLE;
         scnt_reg        <= 4'd0;
         x_reg           <= '0;
         mism_cnt_reg    <= '0;
         first_bad_reg   <= '0;
         first_valid_reg <= 1'b0;
         equal_reg       <= 1'b0;
         minterms_reg    <= '0;
      end else begin
         state_reg       <= state_next;
         scnt_reg        <= scnt_next;
         x_reg           <= x_next;
         mism_cnt_reg    <= mism_cnt_next;
         first_bad_reg   <= first_bad_next;
         first_valid_reg <= first_valid_next;
         equal_reg       <= equal_next;
         minterms_reg    <= minterms_next;
      end
   end

   assign bus.x           = x_reg;
   assign bus.busy        = (state_reg == ST_WAIT);
   assign bus.done        = (state_reg == ST_FIN);
   assign bus.equal       = equal_reg;
   assign bus.mism_cnt    = mism_cnt_reg;
   assign bus.first_bad   = first_bad_reg;
   assign bus.first_valid = first_valid_reg;
   assign bus.minterms_a  = minterms_reg;
endmodule
